// File: rtl/filt_iir_inv.sv
// ---------------------------------------------------------------------------
// filt_iir_inv
//
// Inverse IIR filter. It realises A(z)/B(z), which is the inverse of a B/A
// shaping filter:
//
//   y[n] = floor((sum_k a[k]*x[n-k] - sum_{j>=1} b[j]*y[n-j]) / 2^gp_frac_bits)
//
// The result is saturated to gp_oup_width. The leading denominator
// coefficient b[0] is fixed at 2^gp_frac_bits, so slice 0 of i_coeff_b is
// never read.
//
// A single multiplier-accumulator is shared in time, with one product per
// clock. Each accepted sample is processed in four steps:
//   IDLE : accept x[n] and shift the x history
//   MAC  : Na+Nb-1 product cycles (numerator terms first, then feedback terms)
//   OUT  : scale, saturate, register the output and push it into the y history
//   HOLD : present o_data/o_valid until the downstream block takes it
//
// Ports
//   i_clk      : sole clock, rising edge
//   i_rst      : synchronous active-high reset
//   i_data     : signed input sample x[n]
//   i_valid    : i_data valid
//   o_ready    : block can accept a sample (high only in IDLE)
//   i_coeff_a  : numerator taps, a[k] at [k*gp_coeff_width +: gp_coeff_width]
//   i_coeff_b  : denominator taps, same packing; slice 0 ignored
//   o_data     : signed output sample y[n]
//   o_valid    : o_data valid
//   i_ready    : downstream accepts o_data
// ---------------------------------------------------------------------------
module filt_iir_inv #(
  parameter int gp_inp_width   = 16,
  parameter int gp_oup_width   = 16,
  parameter int gp_num_length  = 3,
  parameter int gp_den_length  = 3,
  parameter int gp_coeff_width = 8,
  parameter int gp_frac_bits   = 6
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst,
  input  logic [gp_inp_width-1:0]                  i_data,
  input  logic                                     i_valid,
  output logic                                     o_ready,
  input  logic [gp_num_length*gp_coeff_width-1:0]  i_coeff_a,
  input  logic [gp_den_length*gp_coeff_width-1:0]  i_coeff_b,
  output logic [gp_oup_width-1:0]                  o_data,
  output logic                                     o_valid,
  input  logic                                     i_ready
);

  // The operand mux sign-extends both histories to a common width, so a
  // single multiplier serves both the feed-forward and the feedback terms.
  localparam int lp_smp_w  = (gp_inp_width > gp_oup_width) ? gp_inp_width : gp_oup_width;
  localparam int lp_prod_w = lp_smp_w + gp_coeff_width;
  localparam int lp_taps   = gp_num_length + gp_den_length;
  // Guard bits for the sum of lp_taps products, plus one bit for the
  // subtraction, so the accumulator cannot wrap.
  localparam int lp_acc_w  = lp_prod_w + $clog2(lp_taps) + 1;
  localparam int lp_cnt_w  = $clog2(lp_taps);
  // With Nb=1 there is no feedback. One dummy entry keeps the array legal.
  localparam int lp_yh_len = (gp_den_length > 1) ? gp_den_length - 1 : 1;
  // Index of the final product cycle. The sequence has Na+Nb-1 products.
  localparam int lp_k_last = lp_taps - 2;

  // Saturation bounds, sign-extended to accumulator width.
  localparam logic signed [lp_acc_w-1:0] lp_sat_max =
    {{(lp_acc_w-gp_oup_width+1){1'b0}}, {(gp_oup_width-1){1'b1}}};
  localparam logic signed [lp_acc_w-1:0] lp_sat_min =
    {{(lp_acc_w-gp_oup_width+1){1'b1}}, {(gp_oup_width-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MAC  = 2'b01,
    ST_OUT  = 2'b10,
    ST_HOLD = 2'b11
  } state_t;

  // The arithmetic shift rounds toward minus infinity. The shifted value is
  // then clamped to the output range.
  function automatic logic signed [gp_oup_width-1:0] sat_out(
    input logic signed [lp_acc_w-1:0] acc_v
  );
    logic signed [lp_acc_w-1:0] sh_v;
    sh_v = acc_v >>> gp_frac_bits;
    if (sh_v > lp_sat_max) begin
      sat_out = lp_sat_max[gp_oup_width-1:0];
    end else if (sh_v < lp_sat_min) begin
      sat_out = lp_sat_min[gp_oup_width-1:0];
    end else begin
      sat_out = sh_v[gp_oup_width-1:0];
    end
  endfunction

  state_t                          state_r;
  state_t                          state_next_s;
  logic                            accept_s;
  logic                            ready_r;
  logic                            valid_r;
  logic signed [gp_oup_width-1:0]  data_r;
  logic [lp_cnt_w-1:0]             k_r;
  logic signed [lp_acc_w-1:0]      acc_r;
  logic signed [gp_inp_width-1:0]  x_hist_r [gp_num_length];
  logic signed [gp_oup_width-1:0]  y_hist_r [lp_yh_len];

  logic signed [gp_coeff_width-1:0] coeff_s;
  logic signed [lp_smp_w-1:0]       sample_s;
  logic                             sub_s;
  logic signed [lp_prod_w-1:0]      prod_s;
  logic signed [lp_acc_w-1:0]       prod_ext_s;
  logic signed [lp_acc_w-1:0]       acc_next_s;
  logic signed [gp_oup_width-1:0]   sat_s;
  logic                             unused_coeff_b0_s;

  // b[0] is implicit, so its slice is intentionally left unread.
  assign unused_coeff_b0_s = ^i_coeff_b[gp_coeff_width-1:0];

  // Next-state logic and the sample-accept strobe.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_valid) begin
          accept_s     = 1'b1;
          state_next_s = ST_MAC;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_MAC: begin
        if (k_r == lp_cnt_w'(lp_k_last)) begin
          state_next_s = ST_OUT;
        end else begin
          state_next_s = ST_MAC;
        end
      end
      ST_OUT: begin
        state_next_s = ST_HOLD;
      end
      ST_HOLD: begin
        if (i_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register. o_ready is registered from the next state, so it is
  // high exactly while the block sits in IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_next_s;
      ready_r <= (state_next_s == ST_IDLE);
    end
  end

  // Operand selection for the shared multiplier. Cycles k < Na take
  // a[k]*x[n-k]. The remaining cycles take b[j]*y[n-j], with j = k-Na+1,
  // and subtract that product.
  always_comb begin
    coeff_s  = '0;
    sample_s = '0;
    sub_s    = 1'b0;
    for (int i = 0; i < gp_num_length; i++) begin
      if (k_r == lp_cnt_w'(i)) begin
        coeff_s  = $signed(i_coeff_a[i*gp_coeff_width +: gp_coeff_width]);
        sample_s = lp_smp_w'(x_hist_r[i]);
      end else begin
      end
    end
    for (int j = 1; j < gp_den_length; j++) begin
      if (k_r == lp_cnt_w'(gp_num_length + j - 1)) begin
        coeff_s  = $signed(i_coeff_b[j*gp_coeff_width +: gp_coeff_width]);
        sample_s = lp_smp_w'(y_hist_r[j-1]);
        sub_s    = 1'b1;
      end else begin
      end
    end
  end

  assign prod_s     = lp_prod_w'(coeff_s) * lp_prod_w'(sample_s);
  assign prod_ext_s = lp_acc_w'(prod_s);
  assign acc_next_s = sub_s ? (acc_r - prod_ext_s) : (acc_r + prod_ext_s);
  assign sat_s      = sat_out(acc_r);

  // Datapath: histories, accumulator, tap counter and the output register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      k_r     <= '0;
      acc_r   <= '0;
      data_r  <= '0;
      valid_r <= 1'b0;
      for (int i = 0; i < gp_num_length; i++) begin
        x_hist_r[i] <= '0;
      end
      for (int j = 0; j < lp_yh_len; j++) begin
        y_hist_r[j] <= '0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            for (int i = gp_num_length - 1; i > 0; i--) begin
              x_hist_r[i] <= x_hist_r[i-1];
            end
            x_hist_r[0] <= i_data;
            acc_r       <= '0;
            k_r         <= '0;
          end
        end
        ST_MAC: begin
          acc_r <= acc_next_s;
          k_r   <= k_r + lp_cnt_w'(1);
        end
        ST_OUT: begin
          data_r  <= sat_s;
          valid_r <= 1'b1;
          // The y history stores the saturated value, which is the value
          // the downstream block actually sees.
          for (int j = lp_yh_len - 1; j > 0; j--) begin
            y_hist_r[j] <= y_hist_r[j-1];
          end
          y_hist_r[0] <= sat_s;
        end
        ST_HOLD: begin
          if (i_ready) begin
            valid_r <= 1'b0;
          end
        end
        default: begin
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign o_data  = data_r;
  assign o_valid = valid_r;
  assign o_ready = ready_r;

endmodule
